// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//
// Steps every instruction through phases 1..5 for the control decoder and
// holds phase at 0 whenever the processor is stopped. Owns the run / stop /
// single-step / halt state, driven by two operator push-buttons and the
// decoder's halt flag, and counts completed instructions.
//
// Optional feature macro: PHASE_SEQUENCER_DEBOUNCE_EN
//   defined   : each synchronized button passes through a debouncer that needs
//               DEBOUNCE_CYCLES consecutive disagreeing cycles to flip.
//   undefined : edge detection uses the synchronizer output directly.
//
// Ports:
//   i_clk            system clock, all state on the rising edge
//   i_reset          synchronous active-high reset
//   i_exec           run/stop push-button, raw asynchronous level
//   i_step           single-step push-button, raw asynchronous level
//   i_hlt            halt flag from the decoder, sampled only in phase 5
//   o_phase          0 when stopped, otherwise 1..5
//   o_running        high in RUN or STEP
//   o_halted         high in HALTED
//   o_stop_pending   stop requested in RUN, honoured at the instruction boundary
//   o_instr_count    completed instructions, modulo 2^16
// -----------------------------------------------------------------------------
module phase_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_exec,
    input  logic        i_step,
    input  logic        i_hlt,
    output logic [2:0]  o_phase,
    output logic        o_running,
    output logic        o_halted,
    output logic        o_stop_pending,
    output logic [15:0] o_instr_count
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("phase_sequencer: DEBOUNCE_CYCLES must be at least 1");
    end

    // Button lanes: bit 0 = exec, bit 1 = step.
    localparam int NB = 2;

    logic [NB-1:0] w_btn_raw;
    logic [NB-1:0] r_sync1;
    logic [NB-1:0] r_sync2;
    logic [NB-1:0] w_btn_lvl;
    logic [NB-1:0] r_btn_prev;
    logic [NB-1:0] w_btn_rise;
    logic          w_exec_rise;
    logic          w_step_rise;

    assign w_btn_raw = {i_step, i_exec};

    // Two-flop synchronizer on both raw button levels.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PHASE_SEQUENCER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NB-1:0]         r_stable;
    logic [NB-1:0][CW-1:0] r_db_cnt;

    // The counter tracks how long the synchronized level has disagreed with
    // the accepted level; a single agreeing cycle starts the wait over.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stable <= '0;
            r_db_cnt <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (r_sync2[b] != r_stable[b]) begin
                    if (r_db_cnt[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        r_stable[b] <= r_sync2[b];
                        r_db_cnt[b] <= '0;
                    end else begin
                        r_db_cnt[b] <= r_db_cnt[b] + CW'(1);
                    end
                end else begin
                    r_db_cnt[b] <= '0;
                end
            end
        end
    end

    assign w_btn_lvl = r_stable;
`else
    assign w_btn_lvl = r_sync2;
`endif

    // Rising-edge detect: a held button yields one pulse, falling edges are dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_btn_prev <= '0;
        else         r_btn_prev <= w_btn_lvl;
    end

    assign w_btn_rise  = w_btn_lvl & ~r_btn_prev;
    assign w_exec_rise = w_btn_rise[0];
    assign w_step_rise = w_btn_rise[1];

    // -------------------------------------------------------------------------
    // Sequencer FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      r_state,  w_state_nxt;
    logic [2:0]  r_phase,  w_phase_nxt;
    logic        r_stop,   w_stop_nxt;
    logic [15:0] r_count,  w_count_nxt;

    // State register (phase, stop request and count travel with the state).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_phase <= 3'd0;
            r_stop  <= 1'b0;
            r_count <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_stop  <= w_stop_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_stop_nxt  = r_stop;
        w_count_nxt = r_count;
        unique case (r_state)
            S_IDLE: begin
                // exec wins when both buttons rise together
                if (w_exec_rise) begin
                    w_state_nxt = S_RUN;
                    w_phase_nxt = 3'd1;
                end else if (w_step_rise) begin
                    w_state_nxt = S_STEP;
                    w_phase_nxt = 3'd1;
                end
            end
            S_RUN, S_STEP: begin
                // A repeat exec press only re-sets the request; it never cancels.
                if (r_state == S_RUN && w_exec_rise) w_stop_nxt = 1'b1;
                if (r_phase == 3'd5) begin
                    // Count before deciding, so halted/stopped instructions count too.
                    w_count_nxt = r_count + 16'd1;
                    if (i_hlt) begin
                        w_state_nxt = S_HALTED;
                        w_phase_nxt = 3'd0;
                        w_stop_nxt  = 1'b0;
                    end else if (r_state == S_STEP || r_stop) begin
                        w_state_nxt = S_IDLE;
                        w_phase_nxt = 3'd0;
                        w_stop_nxt  = 1'b0;
                    end else begin
                        w_phase_nxt = 3'd1;
                    end
                end else begin
                    w_phase_nxt = r_phase + 3'd1;
                end
            end
            S_HALTED: begin
                // Only reset leaves; buttons and hlt are ignored.
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = 3'd0;
                w_stop_nxt  = 1'b0;
            end
        endcase
    end

    // Outputs, decoded from registers only.
    always_comb begin
        o_phase        = r_phase;
        o_running      = (r_state == S_RUN) || (r_state == S_STEP);
        o_halted       = (r_state == S_HALTED);
        o_stop_pending = r_stop;
        o_instr_count  = r_count;
    end

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

`ifdef PHASE_SEQUENCER_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif
    localparam int unsigned DBP = (DB > 0) ? DB : 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        exec_b = 1'b0;
    logic        step_b = 1'b0;
    logic        hlt = 1'b0;
    logic [2:0]  phase;
    logic        running;
    logic        halted;
    logic        stop_pending;
    logic [15:0] instr_count;

    always #5 clk = ~clk;

    phase_sequencer #(.DEBOUNCE_CYCLES(DBP)) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_exec(exec_b),
        .i_step(step_b),
        .i_hlt(hlt),
        .o_phase(phase),
        .o_running(running),
        .o_halted(halted),
        .o_stop_pending(stop_pending),
        .o_instr_count(instr_count)
    );

    typedef struct {
        logic [2:0]  ph;
        logic        run;
        logic        hal;
        logic        stp;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // ---------------- reference model ----------------
    // Modes: 0 idle, 1 run, 2 step, 3 halted.
    int m_mode  = 0;
    int m_phase = 0;
    bit m_stop  = 0;
    int m_cnt   = 0;
    // Per button: last three raw samples (oldest first), accepted level,
    // level seen one edge earlier, and consecutive disagreeing cycles.
    bit hq[2][3];
    bit st[2];
    bit lprev[2];
    int dc[2];

    task automatic model_edge(input bit r, input bit e, input bit s, input bit h);
        bit raw[2];
        bit rs[2];
        bit lvl;
        raw[0] = e;
        raw[1] = s;
        if (r) begin
            m_mode = 0; m_phase = 0; m_stop = 0; m_cnt = 0;
            for (int b = 0; b < 2; b++) begin
                hq[b][0] = 0; hq[b][1] = 0; hq[b][2] = 0;
                st[b] = 0; lprev[b] = 0; dc[b] = 0;
            end
            return;
        end
        for (int b = 0; b < 2; b++) begin
            // A raw level takes two edges to be visible through the synchronizer.
            lvl = (DB > 0) ? st[b] : hq[b][1];
            rs[b] = lvl & ~lprev[b];
            lprev[b] = lvl;
            if (DB > 0) begin
                if (hq[b][1] != st[b]) begin
                    dc[b]++;
                    if (dc[b] == DB) begin st[b] = hq[b][1]; dc[b] = 0; end
                end else dc[b] = 0;
            end
            hq[b][0] = hq[b][1];
            hq[b][1] = hq[b][2];
            hq[b][2] = raw[b];
        end
        case (m_mode)
            0: begin
                if (rs[0])      begin m_mode = 1; m_phase = 1; end
                else if (rs[1]) begin m_mode = 2; m_phase = 1; end
            end
            1, 2: begin
                if (m_phase == 5) begin
                    m_cnt = (m_cnt + 1) % 65536;
                    if (h) begin
                        m_mode = 3; m_phase = 0; m_stop = 0;
                    end else if (m_mode == 2 || m_stop) begin
                        m_mode = 0; m_phase = 0; m_stop = 0;
                    end else begin
                        m_phase = 1;
                        if (m_mode == 1 && rs[0]) m_stop = 1;
                    end
                end else begin
                    m_phase = m_phase + 1;
                    if (m_mode == 1 && rs[0]) m_stop = 1;
                end
            end
            default: ;
        endcase
    endtask

    // Drive one cycle's inputs and queue the outputs expected after the next edge.
    task automatic apply(input bit r, input bit e, input bit s, input bit h);
        exp_t x;
        reset = r; exec_b = e; step_b = s; hlt = h;
        model_edge(r, e, s, h);
        x.ph  = 3'(m_phase);
        x.run = (m_mode == 1) || (m_mode == 2);
        x.hal = (m_mode == 3);
        x.stp = m_stop;
        x.cnt = 16'(m_cnt);
        q.push_back(x);
    endtask

    task automatic cyc(input bit r, input bit e, input bit s, input bit h);
        @(negedge clk);
        apply(r, e, s, h);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic press(input bit e, input bit s, input int n);
        for (int i = 0; i < n; i++) cyc(0, e, s, 0);
    endtask

    // Advance until the DUT is expected to be showing phase p (bounded).
    task automatic until_phase(input int p);
        for (int i = 0; i < 40 && m_phase != p; i++) cyc(0, 0, 0, 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("phase",        16'(phase),        16'(x.ph));
                chk("running",      16'(running),      16'(x.run));
                chk("halted",       16'(halted),       16'(x.hal));
                chk("stop_pending", 16'(stop_pending), 16'(x.stp));
                chk("instr_count",  instr_count,       x.cnt);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int he, hs;
        bit e, s, h, r;
        he = 0; hs = 0;

        // reset then idle
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        idle(20);

        // free run: exec held 3 cycles, at least 10 instructions
        press(1, 0, 3 + DB);
        idle(55);

        // stop request raised while phase 2
        until_phase(2);
        press(1, 0, 3 + DB);
        idle(15);

        // single step
        press(0, 1, 2 + DB);
        idle(10);

        // simultaneous exec and step: exec wins
        press(1, 1, 2 + DB);
        idle(12);
        press(1, 0, 2 + DB);
        idle(15);

        // halt: hlt in phases 2..4 only, then in phase 5
        press(1, 0, 2 + DB);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, (m_phase >= 2 && m_phase <= 4));
        until_phase(5);
        cyc(0, 0, 0, 1);
        press(1, 0, 3 + DB);
        idle(3);
        press(0, 1, 3 + DB);
        idle(8);
        cyc(1, 0, 0, 0);
        idle(4);

        // counter wrap: preload near the top while idle
        @(negedge clk);
        dut.r_count = 16'hFFFC;
        m_cnt = 16'hFFFC;
        apply(0, 0, 0, 0);
        press(1, 0, 2 + DB);
        idle(30);
        press(1, 0, 2 + DB);
        idle(15);

        // reset mid-instruction in phase 3
        press(1, 0, 2 + DB);
        until_phase(3);
        cyc(1, 0, 0, 0);
        idle(5);

        // randomized stimulus
        for (int i = 0; i < 6000; i++) begin
            if (he > 0) begin e = 1; he--; end
            else begin e = 0; if ($urandom_range(0, 24) == 0) he = $urandom_range(1, 8); end
            if (hs > 0) begin s = 1; hs--; end
            else begin s = 0; if ($urandom_range(0, 29) == 0) hs = $urandom_range(1, 8); end
            h = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 299) == 0);
            cyc(r, e, s, h);
        end
        idle(5);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d entries left expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

- Generates the 3-bit `phase` that drives the instruction control decoder, sequencing each instruction through phases 1–5.
- Holds `phase` at 0 whenever the processor is stopped; the control decoder treats phase 0 as "all enables off".
- Owns run/stop/single-step/halt state, driven by two operator push-buttons and the decoder's `hlt` flag.
- Counts completed instructions.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a button level is accepted (used only when debounce is compiled in); ≥1.

Ports:
- `clk`  in  1  system clock. One clock; all state on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `exec`  in  1  run/stop push-button, raw asynchronous level.
- `step`  in  1  single-step push-button, raw asynchronous level.
- `hlt`  in  1  halt flag from the control decoder, combinational from the current instruction.
- `phase`  out  3  current phase: 0 (stopped) or 1..5.
- `running`  out  1  high in RUN or STEP state.
- `halted`  out  1  high in HALTED state.
- `stop_pending`  out  1  stop requested in RUN; takes effect at the next instruction boundary.
- `instr_count`  out  16  number of completed instructions, modulo 2^16.

## Operation
Button path (`exec`, `step` each):
- Two-flop synchronizer.
- Optional debounce stage (see Configuration).
- Previous-value flop; one-cycle rising-edge pulse `exec_rise` / `step_rise`.
- Falling edges are ignored.

State machine: IDLE, RUN, STEP, HALTED. All are registered; outputs come from flops.

IDLE (`phase` = 0):
- `exec_rise` → RUN, `phase` ← 1.
- Else `step_rise` → STEP, `phase` ← 1. If both rise in the same cycle, `exec` wins.

RUN / STEP:
- `phase` advances 1→2→3→4→5 one step per cycle.
- Leaving phase 5 completes an instruction: `instr_count` += 1, wrapping 0xFFFF→0x0000. The increment happens before the HALTED/IDLE decision below.
- Decision on leaving phase 5, highest priority first:
  - `hlt`=1 → HALTED, `phase` ← 0.
  - STEP, or RUN with `stop_pending`=1 → IDLE, `phase` ← 0, `stop_pending` ← 0.
  - Otherwise (RUN only) → `phase` ← 1.
- `hlt` is sampled only in phase 5. Its value in phases 1–4 is ignored.

`stop_pending` and button edges while active:
- Set by `exec_rise` in RUN during any phase.
- A second `exec_rise` while set has no effect; it does not cancel.
- `step_rise` is ignored in RUN and STEP.
- `exec_rise` is ignored in STEP.

HALTED (`phase` = 0, `halted` = 1):
- All button edges are ignored.
- Only `reset` leaves this state.

Reset:
- Every output and internal flop returns to its reset value at the next edge with `reset`=1, from any state or phase.
- A reset mid-instruction abandons the instruction; `instr_count` is not incremented.

## Timing
Reset values:
- `phase`=0, `running`=0, `halted`=0, `stop_pending`=0, `instr_count`=0.
- State IDLE; synchronizer, debounce and edge flops all 0.

Latencies:
- Start: raw `exec` first sampled high at edge k → `phase`=1 and `running`=1 after edge k+2. With debounce compiled in: after edge k+2+`DEBOUNCE_CYCLES`.
- Instruction period: exactly 5 cycles. `phase` is 5 for exactly one cycle per instruction.
- Halt: `hlt`=1 while `phase`=5 → `phase`=0 and `halted`=1 after the next edge.
- Stop: `stop_pending` rises the edge after `exec_rise` and falls together with `phase` going to 0.
- A button held high produces exactly one rise pulse.

## Configuration
- Macro: `PHASE_SEQUENCER_DEBOUNCE_EN`.
- Defined: each synchronized button feeds a debouncer.
  - The stable value flips only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any agreeing cycle clears the counter.
  - Edge detection uses the stable value.
- Undefined: edge detection uses the synchronizer output directly. `DEBOUNCE_CYCLES` is unused and no counter is built.

## Test plan
- Reset then idle: assert `reset` 2 cycles, hold buttons low 20 cycles → `phase`=0, `running`=0, `instr_count`=0 throughout.
- Free run: pulse `exec` (held 3 cycles), `hlt`=0 → `phase` sequence 1,2,3,4,5,1… with period 5; after 10 instructions, `instr_count`=10.
- Stop at boundary: in RUN, raise `exec` while `phase`=2 → `stop_pending`=1. Phases 3,4,5 complete, then `phase`=0, state IDLE, `stop_pending`=0, count incremented once.
- Single step and priority: in IDLE, raise `step` → one 1..5 sequence then `phase`=0, `instr_count`+1. Raise `exec` and `step` on the same cycle → RUN.
- Halt: drive `hlt`=1 in phases 2–4 only → no effect. Drive `hlt`=1 in phase 5 → `phase`=0, `halted`=1. `exec`/`step` pulses are then ignored; `reset` restores IDLE.
- Wrap and mid-instruction reset, each a separate run:
  - Force 65535 completed instructions, then one more → `instr_count`=0.
  - Assert `reset` while `phase`=3 → all outputs return to reset values after one edge.
  - With `PHASE_SEQUENCER_DEBOUNCE_EN` and `DEBOUNCE_CYCLES`=4: a 3-cycle `exec` glitch → no start; a 6-cycle press → start at k+6.
